// File: rtl/uart_echo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_echo_ctrl
//
// Receive-to-transmit echo controller placed between a uart instance and the
// top level. The end of each received word is detected on the falling edge of
// rx_busy. When echo is enabled, the word is queued in a circular FIFO. The
// words are then re-sent through the tx_wr / tx_busy handshake of the uart.
//
// Parameters
//   DATA_W      width of rx/tx words
//   FIFO_DEPTH  FIFO entries (power of 2, >= 2)
//   BUSY_TO     cycles to wait for tx_busy after tx_wr before the word is
//               treated as accepted (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   rx_busy     uart receiver busy (same clock domain)
//   rx_data     received word, valid when rx_busy is first sampled low
//   tx_busy     uart transmitter busy
//   echo_en     1: received words are queued for echo; 0: shown on rx_led only
//   clr_ovf     synchronous clear of overflow
//   tx_wr       one-cycle write strobe to the uart
//   tx_data     word to transmit, held from tx_wr until the next pop
//   rx_led      last received word (raw)
//   fifo_count  current FIFO occupancy
//   overflow    sticky flag, set when a word is dropped because the FIFO is full
//
// Optional feature (macro UART_ECHO_UPCASE_EN, needs DATA_W >= 8): a word
// whose low byte is ASCII 'a'..'z' is queued as uppercase. rx_led still shows
// the raw word.
// -----------------------------------------------------------------------------
module uart_echo_ctrl #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BUSY_TO    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_busy,
  input  logic [DATA_W-1:0]             rx_data,
  input  logic                          tx_busy,
  input  logic                          echo_en,
  input  logic                          clr_ovf,
  output logic                          tx_wr,
  output logic [DATA_W-1:0]             tx_data,
  output logic [DATA_W-1:0]             rx_led,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BUSY_TO + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TO_LAST  = CW'(BUSY_TO - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_e;

  state_e              state_q;
  logic                rx_busy_q;
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [AW:0]         count_q, count_d;
  logic                ovf_q;
  logic [DATA_W-1:0]   rx_led_q;
  logic                tx_wr_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic [CW-1:0]       to_cnt_q;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic                rx_done;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;
  logic [DATA_W-1:0]   wdata;

  // End of a received word: busy seen high last cycle and low now.
  assign rx_done = rx_busy_q & ~rx_busy;
  assign full    = (count_q == FULL_CNT);
  // The FSM pops the head only from IDLE, so a pop always reads a valid entry.
  assign pop     = (state_q == IDLE) && (count_q != '0) && !tx_busy;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push    = rx_done && echo_en && (!full || pop);
  assign drop    = rx_done && echo_en && full && !pop;

`ifdef UART_ECHO_UPCASE_EN
  always_comb begin
    wdata = rx_data;
    if (rx_data[7:0] >= 8'h61 && rx_data[7:0] <= 8'h7A) wdata[5] = 1'b0;
  end
`else
  assign wdata = rx_data;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_busy_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rx_led_q  <= '0;
    end else begin
      rx_busy_q <= rx_busy;
      count_q   <= count_d;
      if (rx_done) rx_led_q <= rx_data;
      if (push)    wptr_q   <= wptr_q + AW'(1);
      if (pop)     rptr_q   <= rptr_q + AW'(1);
      // Set has priority over clear.
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset. The pointers and count define which
  // entries are valid, so clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_wr_q   <= 1'b0;
      tx_data_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q <= mem_q[rptr_q];
            tx_wr_q   <= 1'b1;
            to_cnt_q  <= '0;
            state_q   <= WAIT_BUSY;
          end else begin
            tx_wr_q   <= 1'b0;
          end
        end
        WAIT_BUSY: begin
          tx_wr_q <= 1'b0;
          if (tx_busy)                  state_q  <= WAIT_DONE;
          // The uart never started; count the word as sent, do not retry.
          else if (to_cnt_q == TO_LAST) state_q  <= IDLE;
          else                          to_cnt_q <= to_cnt_q + CW'(1);
        end
        WAIT_DONE: begin
          tx_wr_q <= 1'b0;
          if (!tx_busy) state_q <= IDLE;
        end
        default: begin
          tx_wr_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_wr      = tx_wr_q;
  assign tx_data    = tx_data_q;
  assign rx_led     = rx_led_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/uart_echo_ctrl.md
Name: uart_echo_ctrl

Overview:
- Parametrised receive-to-transmit echo controller that sits between the board pins' `uart` instance and the top level.
- Detects end of each received word on the falling edge of `rx_busy`, buffers words in a FIFO, and re-transmits them through the `tx_wr`/`tx_busy` handshake.
- Exposes the last received word on `rx_led`, plus FIFO occupancy and a sticky overflow flag.

Parameters:
- DATA_W, 8: width of rx/tx data words.
- FIFO_DEPTH, 16: FIFO entries; power of 2, ≥2.
- BUSY_TO, 4: cycles to wait for `tx_busy` to rise after a `tx_wr` pulse before the word is treated as accepted; ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_busy  in  1  from uart; high while a word is being received; same clock domain.
- rx_data  in  DATA_W  from uart; valid on the cycle `rx_busy` is first sampled low after being high.
- tx_busy  in  1  from uart; high while transmitting.
- echo_en  in  1  1 = received words are pushed to FIFO; 0 = received words are shown on `rx_led` only.
- clr_ovf  in  1  synchronous clear of `overflow`.
- tx_wr  out  1  one-cycle write strobe to uart.
- tx_data  out  DATA_W  word to transmit; held stable from `tx_wr` until the next pop.
- rx_led  out  DATA_W  last received word.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when a word is dropped because the FIFO is full.

Behaviour:
- Reset (async, any time, including mid-transmit):
  - Outputs: `tx_wr`=0, `tx_data`=0, `rx_led`=0, `fifo_count`=0, `overflow`=0.
  - FIFO pointers cleared; FSM goes to IDLE; `rx_busy_q`=0.
  - No strobe is emitted when reset is released.
- Receive detect: `rx_busy_q` is `rx_busy` registered. `rx_done` = `rx_busy_q` & ~`rx_busy` (combinational, one cycle).
- On the edge where `rx_done`=1:
  - `rx_led` <= `rx_data` (always, regardless of `echo_en`).
  - If `echo_en`=1 and the FIFO is not full, or it is full and a pop occurs on the same edge: write `rx_data` at `wptr`, advance `wptr`.
  - If `echo_en`=1, the FIFO is full and there is no pop on that edge: word dropped, `overflow` <= 1.
- `overflow`: `clr_ovf` clears it. If a set and a clear occur on the same edge, the set wins.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - `fifo_count` +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Simultaneous push and pop on an empty FIFO is impossible: a pop requires `fifo_count`>0 at the edge.
- TX FSM, states IDLE, WAIT_BUSY, WAIT_DONE:
  - IDLE: if `fifo_count`>0 and `tx_busy`=0, pop the head: `tx_data` <= head, `tx_wr` <= 1, timeout counter <= 0, go to WAIT_BUSY. Otherwise `tx_wr` <= 0.
  - WAIT_BUSY: `tx_wr` <= 0.
    - If `tx_busy`=1, go to WAIT_DONE.
    - Else if counter = BUSY_TO-1, go to IDLE (word treated as accepted, not retried).
    - Else counter +1.
  - WAIT_DONE: if `tx_busy`=0, go to IDLE.
- `tx_wr` is a registered output and is never high for two consecutive cycles.
- Latency: `rx_busy` sampled low after high at edge E → push at E → `tx_wr`=1 in the cycle after edge E+1, given the FIFO was empty, the FSM was in IDLE and `tx_busy`=0.
- `echo_en` deasserted with words still queued: queued words still drain; only new pushes stop.
- `rx_busy` stuck high: no push; the FSM is unaffected.

Optional Feature:
- Macro: UART_ECHO_UPCASE_EN.
- Defined (requires DATA_W ≥ 8): a word whose low 8 bits are in 0x61..0x7A is pushed with bit 5 cleared (ASCII lowercase → uppercase). `rx_led` still shows the raw word.
- Undefined: words are pushed unmodified; no extra logic.

Test Plan:
- Reset mid-transmit: assert `reset` while in WAIT_DONE with 3 words queued → same cycle `tx_wr`=0, `fifo_count`=0, `tx_data`=0. After release, no `tx_wr` while `rx_busy` stays low.
- Single echo: receive 0x41 (`rx_busy` 1→0), `tx_busy`=0 → `rx_led`=0x41, `tx_wr` high exactly one cycle, 2 edges after the falling sample, with `tx_data`=0x41. Raise `tx_busy` 1 cycle later for 10 cycles → no further `tx_wr`.
- Back-pressure and order: hold `tx_busy`=1, receive 0x01..0x05 → `fifo_count`=5. Release `tx_busy`, model a uart busy for 8 cycles per word → transmits 0x01,0x02,0x03,0x04,0x05 in order; `fifo_count` ends at 0.
- Overflow and wrap: FIFO_DEPTH=4, `tx_busy`=1, receive 6 words → `fifo_count`=4 and `overflow`=1. Pulse `clr_ovf` → `overflow`=0. Drain → first 4 words out. Then receive 4 more → correct order across pointer wrap.
- Timeout: `tx_busy` never rises after `tx_wr` → FSM back to IDLE after BUSY_TO=4 cycles; the next queued word is strobed in the following cycle.
- UART_ECHO_UPCASE_EN defined: receive 0x61, 0x7B, 0x5A → transmits 0x41, 0x7B, 0x5A; `rx_led` last shows 0x5A.
